// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: byte width, baud rate and the
// receive-controller handshake state type.
package uart_pkg;

  localparam int UART_BYTE_W = 8;
  localparam int UART_BAUD   = 115200;

  typedef enum logic [0:0] {
    RX_IDLE = 1'b0,
    RX_ACK  = 1'b1
  } rx_ctrl_state_t;

  // Saturating 8-bit increment used by event counters.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/uart_rx_ctrl_if.sv
// Byte handshake with the serial receiver plus the valid/ready byte stream
// towards the consumer; slave is the controller's view, master the environment's.
interface uart_rx_ctrl_if;
  import uart_pkg::*;

  logic [UART_BYTE_W-1:0] rx_data;
  logic                   rx_finish;
  logic                   rx_ready;
  logic [UART_BYTE_W-1:0] dout;
  logic                   dout_valid;
  logic                   dout_ready;

  modport slave (
    input  rx_data, rx_finish, dout_ready,
    output rx_ready, dout, dout_valid
  );

  modport master (
    output rx_data, rx_finish, dout_ready,
    input  rx_ready, dout, dout_valid
  );

endinterface

// File: rtl/uart_rx_ctrl_byte_fifo.sv
// Module byte_fifo: first-word fall-through byte FIFO with registered occupancy
// and valid, synchronous flush, and a drop strobe for pushes refused while full.
module byte_fifo
  import uart_pkg::*;
#(
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  logic [UART_BYTE_W-1:0] din,
  output logic [UART_BYTE_W-1:0] dout,
  output logic                   dout_valid,
  output logic [AW:0]            level,
  output logic                   drop
);

  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

  logic [UART_BYTE_W-1:0] mem [DEPTH];
  logic [AW-1:0]          wr_ptr;
  logic [AW-1:0]          rd_ptr;
  logic [AW:0]            level_nxt;
  logic                   full;
  logic                   rd_en;
  logic                   wr_en;

  // A same-cycle pop frees the slot a push into a full FIFO needs.
  assign full  = (level == FULL_LVL);
  assign rd_en = pop && dout_valid && !flush;
  assign wr_en = push && !flush && (!full || rd_en);
  assign drop  = push && !flush && full && !rd_en;
  assign dout  = mem[rd_ptr];

  always_comb begin
    // NOTE: default assignment first so every path drives level_nxt and no latch is inferred.
    level_nxt = level;
    if (flush) begin
      level_nxt = '0;
    end else if (wr_en && !rd_en) begin
      level_nxt = level + (AW+1)'(1);
    end else if (rd_en && !wr_en) begin
      level_nxt = level - (AW+1)'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: state uses non-blocking assignments so all registers update together at the edge.
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      level      <= '0;
      dout_valid <= 1'b0;
    end else begin
      level      <= level_nxt;
      dout_valid <= (level_nxt != '0);
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (wr_en) wr_ptr <= wr_ptr + AW'(1);
        if (rd_en) rd_ptr <= rd_ptr + AW'(1);
      end
    end
  end

  // NOTE: storage has no reset; dout is only meaningful while dout_valid is high.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/uart_rx_ctrl.sv
// Receive-side controller: acknowledges each receiver byte once, queues it in a
// byte_fifo and flags drops. Optional drop counter: UART_RX_CTRL_OVR_CNT_EN.
module uart_rx_ctrl
  import uart_pkg::*;
#(
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  uart_rx_ctrl_if.slave        bus,
  input  logic                 flush,
  output logic [AW:0]          level,
  output logic                 ovr,
  input  logic                 ovr_clr,
  output logic [7:0]           ovr_count
);

  localparam logic [0:0] S_IDLE = 1'(RX_IDLE);
  localparam logic [0:0] S_ACK  = 1'(RX_ACK);

  logic [0:0] state;
  logic [0:0] state_nxt;
  logic       capture;
  logic       drop;

  // Capture only on the IDLE->ACK transition, so a long rx_finish yields one byte.
  assign capture     = (state == S_IDLE) && bus.rx_finish;
  assign bus.rx_ready = (state == S_ACK);

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (bus.rx_finish)  state_nxt = S_ACK;
      S_ACK:   if (!bus.rx_finish) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  byte_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (capture),
    .pop        (bus.dout_ready),
    .flush      (flush),
    .din        (bus.rx_data),
    .dout       (bus.dout),
    .dout_valid (bus.dout_valid),
    .level      (level),
    .drop       (drop)
  );

  // A drop on the same edge as a clear leaves the flag set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       ovr <= 1'b0;
    else if (drop)    ovr <= 1'b1;
    else if (ovr_clr) ovr <= 1'b0;
  end

`ifdef UART_RX_CTRL_OVR_CNT_EN
  logic [7:0] drop_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt <= '0;
    end else if (drop) begin
      drop_cnt <= ovr_clr ? 8'd1 : sat_inc8(drop_cnt);
    end else if (ovr_clr) begin
      drop_cnt <= '0;
    end
  end

  assign ovr_count = drop_cnt;
`else
  assign ovr_count = '0;
`endif

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Self-checking bench for uart_rx_ctrl: a queue-based model checked every cycle
// plus directed scenarios with literal expectations.
module tb_uart_rx_ctrl;

  localparam int DEPTH = 16;
`ifdef UART_RX_CTRL_OVR_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       flush;
  logic       ovr_clr;
  logic [4:0] level;
  logic       ovr;
  logic [7:0] ovr_count;

  uart_rx_ctrl_if bus ();

  uart_rx_ctrl #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .flush     (flush),
    .level     (level),
    .ovr       (ovr),
    .ovr_clr   (ovr_clr),
    .ovr_count (ovr_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Model: the FIFO is a queue; the receiver is acknowledged on the cycle after
  // it raises rx_finish, and a new byte is taken whenever rx_finish is high but
  // not yet acknowledged.
  logic [7:0] mq[$];
  bit         m_ovr;
  int         m_cnt;
  bit         m_ready;

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      mq.delete();
      m_ovr   = 1'b0;
      m_cnt   = 0;
      m_ready = 1'b0;
    end else begin
      bit new_byte, pop_now, dropped;
      new_byte = bus.rx_finish && !m_ready;
      pop_now  = bus.dout_ready && (mq.size() > 0);
      dropped  = 1'b0;
      if (flush) begin
        mq.delete();
      end else begin
        if (pop_now) void'(mq.pop_front());
        if (new_byte) begin
          if (mq.size() < DEPTH) mq.push_back(bus.rx_data);
          else                   dropped = 1'b1;
        end
      end
      if (dropped) begin
        m_ovr = 1'b1;
        if (CNT_EN) m_cnt = ovr_clr ? 1 : ((m_cnt >= 255) ? 255 : m_cnt + 1);
      end else if (ovr_clr) begin
        m_ovr = 1'b0;
        m_cnt = 0;
      end
      m_ready = bus.rx_finish;
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      check("rx_ready", bus.rx_ready, m_ready);
      check("dout_valid", bus.dout_valid, mq.size() != 0);
      check("level", level, mq.size());
      check("ovr", ovr, m_ovr);
      check("ovr_count", ovr_count, m_cnt);
      if (mq.size() != 0) check("dout", bus.dout, mq[0]);
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic send_byte(input logic [7:0] b);
    bus.rx_data   = b;
    bus.rx_finish = 1'b1;
    step();
    bus.rx_finish = 1'b0;
    step();
  endtask

  task automatic pop_one();
    bus.dout_ready = 1'b1;
    step();
    bus.dout_ready = 1'b0;
  endtask

  task automatic pulse_clr();
    ovr_clr = 1'b1;
    step();
    ovr_clr = 1'b0;
  endtask

  logic [7:0] got[$];
  int         max_lvl;

  task automatic wrap_step();
    if (bus.dout_ready && bus.dout_valid) got.push_back(bus.dout);
    step();
    if (int'(level) > max_lvl) max_lvl = int'(level);
    bus.dout_ready = !bus.dout_ready;
  endtask

  initial begin
    rst_n          = 1'b0;
    flush          = 1'b0;
    ovr_clr        = 1'b0;
    bus.rx_data    = '0;
    bus.rx_finish  = 1'b0;
    bus.dout_ready = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    check("rst_rx_ready", bus.rx_ready, 1'b0);
    check("rst_dout_valid", bus.dout_valid, 1'b0);
    check("rst_level", level, 0);
    check("rst_ovr", ovr, 1'b0);
    check("rst_ovr_count", ovr_count, 0);
    rst_n = 1'b1;
    step();

    // Single byte held for 20 cycles.
    bus.rx_data   = 8'h5A;
    bus.rx_finish = 1'b1;
    step();
    check("single_ready", bus.rx_ready, 1'b1);
    check("single_valid", bus.dout_valid, 1'b1);
    check("single_dout", bus.dout, 8'h5A);
    repeat (19) step();
    check("single_no_dup", level, 1);
    bus.rx_finish = 1'b0;
    check("single_ready_held", bus.rx_ready, 1'b1);
    step();
    check("single_ready_fall", bus.rx_ready, 1'b0);
    pop_one();
    check("single_drained", level, 0);

    // Burst of 18 into a stalled consumer.
    for (int i = 0; i < 18; i++) send_byte(8'(i));
    check("burst_level", level, 16);
    check("burst_ovr", ovr, 1'b1);
    check("burst_ovr_count", ovr_count, CNT_EN ? 2 : 0);
    pulse_clr();
    check("burst_clr_ovr", ovr, 1'b0);
    check("burst_clr_count", ovr_count, 0);

    // Full FIFO: new byte arrives together with a pop.
    check("full_head", bus.dout, 8'h00);
    bus.rx_data    = 8'hA5;
    bus.rx_finish  = 1'b1;
    bus.dout_ready = 1'b1;
    step();
    bus.rx_finish  = 1'b0;
    bus.dout_ready = 1'b0;
    check("fullpop_level", level, 16);
    check("fullpop_ovr", ovr, 1'b0);
    step();
    for (int i = 1; i < 16; i++) begin
      check("drain_order", bus.dout, 32'(i));
      pop_one();
    end
    check("fullpop_tail", bus.dout, 8'hA5);
    pop_one();
    check("drain_empty", level, 0);

    // Pointer wrap with a toggling consumer.
    max_lvl = 0;
    for (int i = 0; i < 40; i++) begin
      bus.rx_data   = 8'(8'h30 + i);
      bus.rx_finish = 1'b1;
      wrap_step();
      bus.rx_finish = 1'b0;
      wrap_step();
    end
    for (int k = 0; k < 64 && got.size() < 40; k++) wrap_step();
    bus.dout_ready = 1'b0;
    check("wrap_count", got.size(), 40);
    for (int i = 0; i < 40; i++) begin
      check("wrap_order", (i < got.size()) ? 32'(got[i]) : 32'hFFFF_FFFF, 32'(8'h30 + i));
    end
    check("wrap_max_level", max_lvl <= DEPTH, 1'b1);
    step();

    // Flush: ovr survives, queued bytes vanish.
    for (int i = 0; i < 17; i++) send_byte(8'(8'h80 + i));
    check("flush_pre_ovr", ovr, 1'b1);
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("flush_level", level, 0);
    check("flush_valid", bus.dout_valid, 1'b0);
    check("flush_ovr_kept", ovr, 1'b1);
    for (int i = 0; i < 5; i++) send_byte(8'(8'hC0 + i));
    check("queued5", level, 5);
    bus.rx_data   = 8'hEE;
    bus.rx_finish = 1'b1;
    flush         = 1'b1;
    step();
    flush         = 1'b0;
    bus.rx_finish = 1'b0;
    check("flush_push_level", level, 0);
    check("flush_push_valid", bus.dout_valid, 1'b0);
    check("flush_push_ack", bus.rx_ready, 1'b1);
    check("flush_push_ovr", ovr, 1'b1);
    step();
    pulse_clr();
    check("clr_ovr", ovr, 1'b0);

    // Drop coincident with ovr_clr: set wins.
    for (int i = 0; i < 16; i++) send_byte(8'(8'h40 + i));
    bus.rx_data   = 8'h99;
    bus.rx_finish = 1'b1;
    ovr_clr       = 1'b1;
    step();
    ovr_clr       = 1'b0;
    bus.rx_finish = 1'b0;
    check("setwins_ovr", ovr, 1'b1);
    check("setwins_count", ovr_count, CNT_EN ? 1 : 0);
    step();

    // Counter saturation.
    for (int i = 0; i < 260; i++) send_byte(8'h11);
    check("sat_count", ovr_count, CNT_EN ? 255 : 0);
    check("sat_level", level, 16);

    // Reset while acknowledging; rx_finish stays high through release.
    bus.rx_data   = 8'h77;
    bus.rx_finish = 1'b1;
    step();
    check("mid_ack", bus.rx_ready, 1'b1);
    check("mid_pre_ovr", ovr, 1'b1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_ready", bus.rx_ready, 1'b0);
    check("mid_rst_valid", bus.dout_valid, 1'b0);
    check("mid_rst_level", level, 0);
    check("mid_rst_ovr", ovr, 1'b0);
    check("mid_rst_count", ovr_count, 0);
    step();
    step();
    rst_n = 1'b1;
    step();
    check("post_rst_ack", bus.rx_ready, 1'b1);
    check("post_rst_level", level, 1);
    check("post_rst_dout", bus.dout, 8'h77);
    repeat (5) step();
    check("post_rst_once", level, 1);
    bus.rx_finish = 1'b0;
    step();
    step();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
